// File: rtl/mfp_uart16550_pkg.sv
// Register map, field values and shared types for driving the AHB-Lite UART16550
// from a hardware master.
package mfp_uart16550_pkg;

  localparam logic [2:0] UART_RBR_THR = 3'd0;
  localparam logic [2:0] UART_IER_DLM = 3'd1;
  localparam logic [2:0] UART_FCR     = 3'd2;
  localparam logic [2:0] UART_LCR     = 3'd3;
  localparam logic [2:0] UART_LSR     = 3'd5;

  localparam int LSR_THRE_BIT = 5;

  localparam logic [7:0] LCR_DLAB_8N1 = 8'h83;
  localparam logic [7:0] LCR_8N1      = 8'h03;
  localparam logic [7:0] FCR_EN_CLR   = 8'h07;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {INIT0, INIT1, INIT2, INIT3, INIT4, POLL, READY, SEND} tx_state_t;
  typedef enum logic [1:0] {B_IDLE, B_ADDR, B_DATA} bus_state_t;

  // Registers sit on word boundaries: index n lives at base + 4*n.
  function automatic logic [31:0] uart_reg_addr(input logic [31:0] base, input logic [2:0] idx);
    return base + {27'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/mfp_ahb_lite_single_master.sv
// Single-transfer AHB-Lite engine: one address phase, one data phase, no pipelining.
// done/rdata/err are valid during the cycle whose closing edge completes the transfer.
module mfp_ahb_lite_single_master
  import mfp_uart16550_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  bus_state_t state;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state  <= B_IDLE;
      HTRANS <= HTRANS_IDLE;
      HADDR  <= '0;
      HWRITE <= 1'b0;
      HWDATA <= '0;
    end else begin
      case (state)
        B_IDLE: if (req) begin
          state  <= B_ADDR;
          HTRANS <= HTRANS_NONSEQ;
          HADDR  <= addr;
          HWRITE <= we;
          HWDATA <= wdata;
        end
        B_ADDR: if (HREADY) begin
          state  <= B_DATA;
          HTRANS <= HTRANS_IDLE;
        end
        B_DATA: if (HREADY) state <= B_IDLE;
        default: state <= B_IDLE;
      endcase
    end
  end

  // Requester advances on the same edge the engine drops back to idle.
  assign done  = (state == B_DATA) && HREADY;
  assign rdata = HRDATA[7:0];
  assign err   = done && HRESP;

  logic unused_hrdata;
  assign unused_hrdata = ^HRDATA[31:8];

endmodule

// File: rtl/mfp_ahb_lite_uart_tx_master.sv
// Programs the UART16550 after reset, then streams bytes into THR, polling LSR.THRE
// and spending FIFO credits so the transmit FIFO is never overrun.
//
// state | meaning
// INIT0 | LCR <- 0x83 (open divisor latch, 8N1)
// INIT1 | DLL <- DIVISOR[7:0]
// INIT2 | DLM <- DIVISOR[15:8]
// INIT3 | LCR <- 0x03 (close divisor latch)
// INIT4 | FCR <- 0x07 (enable and clear FIFOs)
// POLL  | read LSR until THRE, then refill credit
// READY | offer tx_ready while credit remains
// SEND  | THR write of the accepted byte in flight
module mfp_ahb_lite_uart_tx_master
  import mfp_uart16550_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1F00_3000,
  parameter logic [15:0] DIVISOR    = 16'd27,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        init_done,
  output logic        bus_error,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [4:0] CREDIT_MAX = 5'(FIFO_DEPTH);

  tx_state_t   state;
  logic [4:0]  credit;
  logic        handshake;
  logic        bus_req;
  logic        bus_we;
  logic [2:0]  bus_reg;
  logic [7:0]  bus_byte;
  logic        bus_done;
  logic        bus_err;
  logic [7:0]  bus_rdata;

  assign handshake = tx_valid && tx_ready;

  // The THR write is requested on the handshake edge itself, giving one byte per 4 cycles.
  always_comb begin
    bus_req  = 1'b1;
    bus_we   = 1'b1;
    bus_reg  = UART_LCR;
    bus_byte = LCR_DLAB_8N1;
    case (state)
      INIT0: ;
      INIT1: begin bus_reg = UART_RBR_THR; bus_byte = DIVISOR[7:0];  end
      INIT2: begin bus_reg = UART_IER_DLM; bus_byte = DIVISOR[15:8]; end
      INIT3: begin bus_reg = UART_LCR;     bus_byte = LCR_8N1;       end
      INIT4: begin bus_reg = UART_FCR;     bus_byte = FCR_EN_CLR;    end
      POLL:  begin bus_we = 1'b0; bus_reg = UART_LSR; bus_byte = 8'h00; end
      READY: begin bus_req = handshake; bus_reg = UART_RBR_THR; bus_byte = tx_data; end
      default: begin bus_req = 1'b0; bus_reg = UART_RBR_THR; bus_byte = 8'h00; end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= INIT0;
      credit    <= '0;
      tx_ready  <= 1'b0;
      init_done <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      if (bus_err) bus_error <= 1'b1;
      case (state)
        INIT0: if (bus_done) state <= INIT1;
        INIT1: if (bus_done) state <= INIT2;
        INIT2: if (bus_done) state <= INIT3;
        INIT3: if (bus_done) state <= INIT4;
        INIT4: if (bus_done) begin
          state     <= POLL;
          init_done <= 1'b1;
        end
        POLL: if (bus_done && bus_rdata[LSR_THRE_BIT]) begin
          credit   <= CREDIT_MAX;
          tx_ready <= 1'b1;
          state    <= READY;
        end
        READY: begin
          if (credit == 5'd0) begin
            state <= POLL;
          end else if (handshake) begin
            credit   <= credit - 5'd1;
            tx_ready <= 1'b0;
            state    <= SEND;
          end
        end
        SEND: if (bus_done) begin
          tx_ready <= (credit != 5'd0);
          state    <= READY;
        end
        default: state <= INIT0;
      endcase
    end
  end

  mfp_ahb_lite_single_master u_bus (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .req    (bus_req),
    .we     (bus_we),
    .addr   (uart_reg_addr(BASE_ADDR, bus_reg)),
    .wdata  ({24'd0, bus_byte}),
    .done   (bus_done),
    .rdata  (bus_rdata),
    .err    (bus_err),
    .HADDR  (HADDR),
    .HTRANS (HTRANS),
    .HWRITE (HWRITE),
    .HWDATA (HWDATA),
    .HRDATA (HRDATA),
    .HREADY (HREADY),
    .HRESP  (HRESP)
  );

  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

  logic unused_rdata;
  assign unused_rdata = ^bus_rdata;

endmodule

// File: tb/tb_mfp_ahb_lite_uart_tx_master.sv
// Directed bench: behavioural UART slave with programmable wait states plus a linear
// stimulus sequence checked with immediate assertions.
module tb_mfp_ahb_lite_uart_tx_master;

  localparam logic [31:0] BASE = 32'h1F00_3000;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready, init_done, bus_error;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HRDATA = 32'h0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // slave knobs and transfer log
  int aw_wait = 0, dw_wait = 1, err_idx = -1, xfer_idx = 0, stable_err = 0;
  int sl_phase = 0, sl_cnt = 0;
  logic [31:0] sl_addr, sl_wdata;
  logic        sl_we;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_we[$];
  int          log_done[$];
  logic [7:0]  lsr_q[$];

  mfp_ahb_lite_uart_tx_master dut (
    .HCLK(HCLK), .HRESET(HRESET), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .init_done(init_done), .bus_error(bus_error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic logic [31:0] la(input int i);
    return (i < log_addr.size()) ? log_addr[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] ld(input int i);
    return (i < log_data.size()) ? log_data[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic lw(input int i);
    return (i < log_we.size()) ? log_we[i] : 1'bx;
  endfunction
  function automatic int ldone(input int i);
    return (i < log_done.size()) ? log_done[i] : -1;
  endfunction
  function automatic logic [7:0] byte_of(input int k);
    return 8'(8'h31 + k * 5);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave: decides HREADY/HRDATA/HRESP for the coming edge at each negedge.
  initial begin
    logic [31:0] rd;
    forever begin
      @(negedge HCLK);
      HRESP  = 1'b0;
      HRDATA = 32'h0;
      rd     = 32'h0;
      if (HRESET) begin
        sl_phase = 0; sl_cnt = 0; HREADY = 1'b1;
      end else if (sl_phase == 0) begin
        if (HTRANS == 2'b10) begin
          if (sl_cnt == 0) begin
            sl_addr = HADDR; sl_we = HWRITE;
          end else if (HADDR !== sl_addr || HWRITE !== sl_we) begin
            stable_err++;
          end
          if (sl_cnt < aw_wait) begin
            HREADY = 1'b0; sl_cnt++;
          end else begin
            HREADY = 1'b1; sl_phase = 1; sl_cnt = 0;
          end
        end else begin
          if (sl_cnt != 0) stable_err++;
          sl_cnt = 0;
          HREADY = 1'b1;
        end
      end else begin
        if (HTRANS !== 2'b00) stable_err++;
        if (sl_cnt == 0) sl_wdata = HWDATA;
        else if (HWDATA !== sl_wdata) stable_err++;
        if (sl_cnt < dw_wait) begin
          HREADY = 1'b0; sl_cnt++;
        end else begin
          HREADY = 1'b1;
          if (!sl_we) begin
            if (sl_addr == BASE + 32'h14 && lsr_q.size() > 0) rd = {24'hDEADBE, lsr_q.pop_front()};
            else rd = {24'hDEADBE, 8'h20};
            HRDATA = rd;
          end
          HRESP = (xfer_idx == err_idx);
          log_addr.push_back(sl_addr);
          log_we.push_back(sl_we);
          log_data.push_back(sl_we ? sl_wdata : {24'h0, rd[7:0]});
          log_done.push_back(cyc + 1);
          xfer_idx++;
          sl_phase = 0; sl_cnt = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] init_a [5];
    logic [7:0]  init_d [5];
    int guard, k, n0, n1, t_done, hs_edge;
    int hs_cyc [18];
    logic hs, ok, ok2;

    init_a = '{BASE + 32'h0C, BASE, BASE + 32'h04, BASE + 32'h0C, BASE + 32'h08};
    init_d = '{8'h83, 8'h1B, 8'h00, 8'h03, 8'h07};

    // reset values
    repeat (3) @(posedge HCLK);
    #2;
    chk("rst HTRANS", 32'(HTRANS), 32'h0);
    chk("rst HADDR", HADDR, 32'h0);
    chk("rst HWRITE", 32'(HWRITE), 32'h0);
    chk("rst HWDATA", HWDATA, 32'h0);
    chk("rst tx_ready", 32'(tx_ready), 32'h0);
    chk("rst init_done", 32'(init_done), 32'h0);
    chk("rst bus_error", 32'(bus_error), 32'h0);
    chk("const HSIZE/HBURST/HPROT/HMASTLOCK", {21'h0, HSIZE, HBURST, HPROT, HMASTLOCK}, {21'h0, 3'b010, 3'b000, 4'b0011, 1'b0});

    // init sequence, error response on the DLM write
    err_idx = 2;
    lsr_q = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h60, 8'h00, 8'h20};
    HRESET = 1'b0;
    guard = 0;
    while (!init_done && guard < 200) begin @(posedge HCLK); #2; guard++; end
    t_done = cyc;
    chk("init_done reached", 32'(init_done), 32'h1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("init%0d addr", i), la(i), init_a[i]);
      chk($sformatf("init%0d data", i), ld(i), {24'h0, init_d[i]});
      chk($sformatf("init%0d write", i), 32'(lw(i)), 32'h1);
    end
    chk("init_done timing", 32'(t_done), 32'(ldone(4)));
    chk("bus_error after DLM HRESP", 32'(bus_error), 32'h1);
    err_idx = -1;

    // polling: five LSR=0x00 then 0x60
    ok = 1'b1; guard = 0;
    while (log_addr.size() < 11 && guard < 200) begin
      if (tx_ready) ok = 1'b0;
      @(posedge HCLK); #2; guard++;
    end
    chk("tx_ready low while polling", 32'(ok), 32'h1);
    ok2 = 1'b1;
    for (int i = 5; i < 11; i++) if (la(i) !== BASE + 32'h14 || lw(i) !== 1'b0) ok2 = 1'b0;
    chk("six LSR reads", 32'(ok2), 32'h1);
    chk("tx_ready after THRE", 32'(tx_ready), 32'h1);

    // 18 bytes back-to-back
    k = 0; guard = 0;
    tx_valid = 1'b1; tx_data = byte_of(0);
    while (k < 18 && guard < 600) begin
      hs = tx_ready;
      @(posedge HCLK); #2; guard++;
      if (hs) begin
        hs_cyc[k] = cyc;
        k++;
        tx_data = byte_of(k);
      end
    end
    tx_valid = 1'b0;
    chk("18 bytes accepted", 32'(k), 32'd18);
    ok = 1'b1;
    for (int i = 1; i < 16; i++) if (hs_cyc[i] - hs_cyc[i-1] != 4) ok = 1'b0;
    chk("4-cycle byte throughput", 32'(ok), 32'h1);
    guard = 0;
    while (log_addr.size() < 31 && guard < 400) begin @(posedge HCLK); #2; guard++; end
    ok2 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (la(11 + i) !== BASE || lw(11 + i) !== 1'b1) ok2 = 1'b0;
      chk($sformatf("THR byte %0d", i), ld(11 + i), {24'h0, byte_of(i)});
    end
    chk("16 THR writes addressed", 32'(ok2), 32'h1);
    chk("LSR read after credit spent", la(27), BASE + 32'h14);
    chk("second LSR read", la(28), BASE + 32'h14);
    chk("THR byte 16", ld(29), {24'h0, byte_of(16)});
    chk("THR byte 17", ld(30), {24'h0, byte_of(17)});
    chk("byte 16 waits for THRE", 32'(hs_cyc[16] >= ldone(28)), 32'h1);
    chk("bus_error sticky", 32'(bus_error), 32'h1);

    // wait states in both phases
    aw_wait = 3; dw_wait = 3;
    n0 = log_addr.size();
    tx_data = 8'hC5; tx_valid = 1'b1;
    hs = 1'b0; guard = 0;
    while (!hs && guard < 50) begin hs = tx_ready; @(posedge HCLK); #2; guard++; end
    hs_edge = cyc;
    tx_valid = 1'b0;
    repeat (30) @(posedge HCLK);
    #2;
    chk("single transfer under waits", 32'(log_addr.size()), 32'(n0 + 1));
    chk("wait THR addr", la(n0), BASE);
    chk("wait THR data", ld(n0), 32'h0000_00C5);
    chk("wait-state latency", 32'(ldone(n0) - hs_edge), 32'd8);
    chk("bus signals stable", 32'(stable_err), 32'h0);
    chk("tx_ready after wait write", 32'(tx_ready), 32'h1);

    // reset during THR data phase
    aw_wait = 0; dw_wait = 3;
    n0 = log_addr.size();
    tx_data = 8'h5A; tx_valid = 1'b1;
    hs = 1'b0; guard = 0;
    while (!hs && guard < 50) begin hs = tx_ready; @(posedge HCLK); #2; guard++; end
    tx_valid = 1'b0;
    guard = 0;
    while (!(sl_phase == 1 && sl_cnt >= 1) && guard < 20) begin @(posedge HCLK); #2; guard++; end
    chk("reached THR data phase", 32'(sl_phase == 1), 32'h1);
    HRESET = 1'b1;
    @(posedge HCLK); #2;
    chk("mid-xfer rst HTRANS", 32'(HTRANS), 32'h0);
    chk("mid-xfer rst HADDR", HADDR, 32'h0);
    chk("mid-xfer rst tx_ready", 32'(tx_ready), 32'h0);
    chk("mid-xfer rst init_done", 32'(init_done), 32'h0);
    chk("mid-xfer rst bus_error", 32'(bus_error), 32'h0);
    @(posedge HCLK); #2;
    HRESET = 1'b0; dw_wait = 1;
    n1 = log_addr.size();
    chk("abandoned write not logged", 32'(n1), 32'(n0));
    guard = 0;
    while (!init_done && guard < 200) begin @(posedge HCLK); #2; guard++; end
    chk("re-init done", 32'(init_done), 32'h1);
    chk("re-init first addr", la(n1), BASE + 32'h0C);
    chk("re-init first data", ld(n1), 32'h0000_0083);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
